// File: rtl/aes_key_expand.sv
// aes_key_expand: iterative AES-128 key schedule filling an 11-entry round-key file, one key per clock.
// Optional AES_KEYEXP_CACHE_EN: a start in READY with key_in equal to rk[0] keeps the existing schedule.
module aes_key_expand #(
    parameter int NROUNDS    = 10,
    parameter int RD_LATENCY = 1
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_i,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic [3:0]   rk_idx,
    output logic [127:0] rk_out,
    output logic         busy,
    output logic         done
);
    typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;
    state_t state, state_n;
    logic [3:0] rcnt, pidx;
    logic [127:0] rk [0:10];
    logic [127:0] prev, rd;
    logic [31:0] t, n0, n1, n2, n3;
    logic [7:0] rcon;
    logic load, hit;

    if (NROUNDS != 10) begin : g_bad
        $error("aes_key_expand supports only NROUNDS=10");
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? p ^ x : p;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Inverse as a^254 via an addition chain, then the FIPS-197 affine map
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] x2, x3, x6, x12, x15, x240, v;
        x2   = gmul(a, a);
        x3   = gmul(x2, a);
        x6   = gmul(x3, x3);
        x12  = gmul(x6, x6);
        x15  = gmul(x12, x3);
        x240 = gmul(x15, x15);
        x240 = gmul(x240, x240);
        x240 = gmul(x240, x240);
        x240 = gmul(x240, x240);
        v    = gmul(gmul(x240, x12), x2);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    always_comb begin
        pidx = (rcnt == 4'd0) ? 4'd0 : rcnt - 4'd1;
        prev = rk[pidx];
        rcon = (rcnt == 4'd9) ? 8'h1b : (rcnt == 4'd10) ? 8'h36 : 8'h01 << (rcnt - 4'd1);
        t    = {sbox(prev[23:16]), sbox(prev[15:8]), sbox(prev[7:0]), sbox(prev[31:24])} ^ {rcon, 24'h0};
        n0   = prev[127:96] ^ t;
        n1   = prev[95:64] ^ n0;
        n2   = prev[63:32] ^ n1;
        n3   = prev[31:0] ^ n2;
`ifdef AES_KEYEXP_CACHE_EN
        hit  = state == READY && key_in == rk[0];
`else
        hit  = 1'b0;
`endif
        load    = start && state != EXPAND && !hit;
        state_n = load ? EXPAND : (state == EXPAND && rcnt == 4'(NROUNDS)) ? READY : state;
        rd      = (rk_idx <= 4'd10) ? rk[rk_idx] : '0;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state <= IDLE;
        else state <= state_n;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            rcnt <= '0;
            for (int i = 0; i <= 10; i++) rk[i] <= '0;
        end else if (load) begin
            rk[0] <= key_in;
            rcnt  <= 4'd1;
        end else if (state == EXPAND) begin
            rk[rcnt] <= {n0, n1, n2, n3};
            rcnt     <= (rcnt == 4'(NROUNDS)) ? rcnt : rcnt + 4'd1;
        end
    end

    assign busy = state == EXPAND;
    assign done = state == READY;

    if (RD_LATENCY == 0) begin : g_comb
        assign rk_out = rd;
    end else begin : g_reg
        always_ff @(posedge wb_clk_i) rk_out <= wb_rst_i ? '0 : rd;
    end
endmodule
